// File: rtl/cnt_opstage_if.sv
// Handshake and data bundle between decode, the operand-staging stage and the count unit.
// master = decode/count-unit side, slave = cnt_opstage.
interface cnt_opstage_if #(
  parameter int WIDTH = 32
);
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] SrcA;
  logic [1:0]       Imm2;
  logic             W64In;
  logic             FlushE;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] RevA;
  logic [1:0]       B;
  logic             W64;

  modport master (
    output InValid, SrcA, Imm2, W64In, FlushE, OutReady,
    input  InReady, OutValid, A, RevA, B, W64
  );

  modport slave (
    input  InValid, SrcA, Imm2, W64In, FlushE, OutReady,
    output InReady, OutValid, A, RevA, B, W64
  );
endinterface

// File: rtl/cnt_opstage.sv
// Operand staging ahead of the clz/ctz/cpop count unit: main + skid buffer,
// bit-reverse precomputed before capture so the count unit starts at a flop.
module cnt_opstage #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  cnt_opstage_if.slave bus
);
  // state   | meaning
  // S_EMPTY | no operation held, outputs invalid
  // S_MAIN  | main entry valid, skid empty
  // S_FULL  | main and skid valid, upstream stalled
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_MAIN  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam bit HAS_W64 = (WIDTH == 64);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_rev_a;
  logic [1:0]       r_b;
  logic             r_w64;
  logic [WIDTH-1:0] r_sk_a;
  logic [WIDTH-1:0] r_sk_rev_a;
  logic [1:0]       r_sk_b;
  logic             r_sk_w64;

  logic [WIDTH-1:0] w_rev_src;
  logic             w_w64_in;
  logic             w_accept;
  logic             w_consume;
  logic             w_main_valid;
  logic             w_load_main;
  logic             w_load_skid;
  logic             w_skid_to_main;

  always_comb begin
    w_rev_src = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_rev_src[i] = bus.SrcA[WIDTH-1-i];
    end
  end

  assign w_w64_in  = HAS_W64 & bus.W64In;
  // r_in_ready mirrors !SkidValid, so accept never looks at OutReady.
  assign w_accept  = bus.InValid & r_in_ready & ~bus.FlushE;
  assign w_consume = w_main_valid & bus.OutReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_FULL);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_MAIN;
      S_MAIN: begin
        if (w_accept && !w_consume)      w_state_nxt = S_FULL;
        else if (!w_accept && w_consume) w_state_nxt = S_EMPTY;
      end
      S_FULL:  if (w_consume) w_state_nxt = S_MAIN;
      default: w_state_nxt = S_EMPTY;
    endcase
    if (bus.FlushE) w_state_nxt = S_EMPTY;
  end

  always_comb begin
    w_main_valid   = (r_state == S_MAIN) || (r_state == S_FULL);
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    case (r_state)
      S_EMPTY: w_load_main = w_accept;
      S_MAIN: begin
        w_load_main = w_accept & bus.OutReady;
        w_load_skid = w_accept & ~bus.OutReady;
      end
      S_FULL:  w_skid_to_main = bus.OutReady & ~bus.FlushE;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_rev_a <= '0;
      r_b     <= '0;
      r_w64   <= 1'b0;
    end else if (w_load_main) begin
      r_a     <= bus.SrcA;
      r_rev_a <= w_rev_src;
      r_b     <= bus.Imm2;
      r_w64   <= w_w64_in;
    end else if (w_skid_to_main) begin
      r_a     <= r_sk_a;
      r_rev_a <= r_sk_rev_a;
      r_b     <= r_sk_b;
      r_w64   <= r_sk_w64;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sk_a     <= '0;
      r_sk_rev_a <= '0;
      r_sk_b     <= '0;
      r_sk_w64   <= 1'b0;
    end else if (w_load_skid) begin
      r_sk_a     <= bus.SrcA;
      r_sk_rev_a <= w_rev_src;
      r_sk_b     <= bus.Imm2;
      r_sk_w64   <= w_w64_in;
    end
  end

  // Ready is held low for the whole reset window, not only after it is sampled.
  assign bus.InReady  = r_in_ready & ~reset;
  assign bus.OutValid = w_main_valid;
  assign bus.A        = r_a;
  assign bus.RevA     = r_rev_a;
  assign bus.B        = r_b;
  assign bus.W64      = r_w64;
endmodule

// File: tb/tb_cnt_opstage.sv
// Directed bench for cnt_opstage: vector table on a 32-bit instance plus
// hand sequences for 64-bit, streaming/stall and mid-operation reset.
module tb_cnt_opstage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cnt_opstage_if #(.WIDTH(32)) b32 ();
  cnt_opstage_if #(.WIDTH(64)) b64 ();

  cnt_opstage #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .bus(b32.slave));
  cnt_opstage #(.WIDTH(64)) u64 (.clk(clk), .reset(reset), .bus(b64.slave));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        vld;
    logic [63:0] src;
    logic [1:0]  imm;
    logic        w64;
    logic        flush;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic [63:0] e_a;
    logic [63:0] e_rev;
    logic [1:0]  e_b;
    logic        e_w64;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl[NV];

  int   sent;
  int   got;
  logic s_ordy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drv32(input logic vld, input logic [31:0] src, input logic [1:0] imm,
                       input logic w64, input logic flush, input logic ordy);
    b32.InValid  = vld;
    b32.SrcA     = src;
    b32.Imm2     = imm;
    b32.W64In    = w64;
    b32.FlushE   = flush;
    b32.OutReady = ordy;
  endtask

  task automatic drv64(input logic vld, input logic [63:0] src, input logic [1:0] imm,
                       input logic w64, input logic flush, input logic ordy);
    b64.InValid  = vld;
    b64.SrcA     = src;
    b64.Imm2     = imm;
    b64.W64In    = w64;
    b64.FlushE   = flush;
    b64.OutReady = ordy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          vld  src                imm    w64   fl    ordy | ov   ir   A                  RevA               B      W64
    tbl[0]  = '{1'b1, 64'h0000_00F0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0000_00F0, 64'h0F00_0000, 2'b01, 1'b0};
    tbl[1]  = '{1'b0, 64'h0,         2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0,         64'h0,         2'b00, 1'b0};
    tbl[2]  = '{1'b1, 64'h1,         2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h1,         64'h8000_0000, 2'b00, 1'b0};
    tbl[3]  = '{1'b1, 64'h2,         2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h1,         64'h8000_0000, 2'b00, 1'b0};
    tbl[4]  = '{1'b1, 64'h5,         2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h1,         64'h8000_0000, 2'b00, 1'b0};
    tbl[5]  = '{1'b0, 64'h0,         2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h2,         64'h4000_0000, 2'b10, 1'b0};
    tbl[6]  = '{1'b0, 64'h0,         2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0,         64'h0,         2'b00, 1'b0};
    tbl[7]  = '{1'b1, 64'hA,         2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'hA,         64'h5000_0000, 2'b00, 1'b0};
    tbl[8]  = '{1'b1, 64'hB,         2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'hA,         64'h5000_0000, 2'b00, 1'b0};
    tbl[9]  = '{1'b1, 64'h3,         2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0,         64'h0,         2'b00, 1'b0};
    tbl[10] = '{1'b0, 64'h0,         2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0,         64'h0,         2'b00, 1'b0};
    tbl[11] = '{1'b1, 64'hC,         2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'hC,         64'h3000_0000, 2'b00, 1'b0};
    tbl[12] = '{1'b1, 64'hD,         2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0,         64'h0,         2'b00, 1'b0};
    tbl[13] = '{1'b0, 64'h0,         2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0,         64'h0,         2'b00, 1'b0};
    tbl[14] = '{1'b1, 64'h8000_0001, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h8000_0001, 64'h8000_0001, 2'b11, 1'b0};
    tbl[15] = '{1'b0, 64'h0,         2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0,         64'h0,         2'b00, 1'b0};

    reset = 1'b1;
    drv32(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    drv64(1'b0, 64'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    tick;
    chk("rst InReady32", 64'(b32.InReady), 64'h0);
    chk("rst OutValid32", 64'(b32.OutValid), 64'h0);
    chk("rst A32", 64'(b32.A), 64'h0);
    chk("rst W64_64", 64'(b64.W64), 64'h0);
    tick;
    reset = 1'b0;
    tick;
    chk("post-rst InReady32", 64'(b32.InReady), 64'h1);
    chk("post-rst InReady64", 64'(b64.InReady), 64'h1);
    chk("post-rst OutValid32", 64'(b32.OutValid), 64'h0);

    for (int k = 0; k < NV; k++) begin
      drv32(tbl[k].vld, tbl[k].src[31:0], tbl[k].imm, tbl[k].w64, tbl[k].flush, tbl[k].ordy);
      tick;
      chk($sformatf("v%0d OutValid", k), 64'(b32.OutValid), 64'(tbl[k].e_ov));
      chk($sformatf("v%0d InReady", k), 64'(b32.InReady), 64'(tbl[k].e_ir));
      if (tbl[k].e_ov) begin
        chk($sformatf("v%0d A", k), 64'(b32.A), tbl[k].e_a);
        chk($sformatf("v%0d RevA", k), 64'(b32.RevA), tbl[k].e_rev);
        chk($sformatf("v%0d B", k), 64'(b32.B), 64'(tbl[k].e_b));
        chk($sformatf("v%0d W64", k), 64'(b32.W64), 64'(tbl[k].e_w64));
      end
    end
    drv32(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1);

    // 64-bit word op and a plain 64-bit op
    drv64(1'b1, 64'h8000_0000_0000_0001, 2'b10, 1'b1, 1'b0, 1'b1);
    tick;
    chk("w64 OutValid", 64'(b64.OutValid), 64'h1);
    chk("w64 A", b64.A, 64'h8000_0000_0000_0001);
    chk("w64 RevA", b64.RevA, 64'h8000_0000_0000_0001);
    chk("w64 B", 64'(b64.B), 64'h2);
    chk("w64 W64", 64'(b64.W64), 64'h1);
    drv64(1'b1, 64'h0000_0000_0000_00F0, 2'b00, 1'b0, 1'b0, 1'b1);
    tick;
    chk("d64 A", b64.A, 64'h0000_0000_0000_00F0);
    chk("d64 RevA", b64.RevA, 64'h0F00_0000_0000_0000);
    chk("d64 W64", 64'(b64.W64), 64'h0);
    drv64(1'b0, 64'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    tick;

    // back-to-back streaming, OutReady held high
    for (int c = 0; c < 9; c++) begin
      drv32(c < 8, 32'h100 + 32'(c), 2'b00, 1'b0, 1'b0, 1'b1);
      tick;
      if (c < 8) begin
        chk($sformatf("strm%0d OutValid", c), 64'(b32.OutValid), 64'h1);
        chk($sformatf("strm%0d A", c), 64'(b32.A), 64'(32'h100 + 32'(c)));
        chk($sformatf("strm%0d InReady", c), 64'(b32.InReady), 64'h1);
      end else begin
        chk("strm end OutValid", 64'(b32.OutValid), 64'h0);
      end
    end

    // streaming with one stall cycle: consumed values must be exactly 0x200..0x207
    sent = 0;
    got  = 0;
    for (int c = 0; c < 20; c++) begin
      s_ordy = (c != 3);
      b32.OutReady = s_ordy;
      if (b32.OutValid && s_ordy) begin
        chk($sformatf("stall got[%0d]", got), 64'(b32.A), 64'(32'h200 + 32'(got)));
        got++;
      end
      b32.InValid = (sent < 8);
      b32.SrcA    = 32'h200 + 32'(sent);
      if (b32.InValid && b32.InReady) sent++;
      tick;
    end
    chk("stall count", 64'(got), 64'h8);
    chk("stall sent", 64'(sent), 64'h8);

    // mid-operation reset with both entries full
    drv32(1'b1, 32'h11, 2'b01, 1'b0, 1'b0, 1'b0);
    drv64(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b1, 1'b0, 1'b0);
    tick;
    drv32(1'b1, 32'h22, 2'b10, 1'b0, 1'b0, 1'b0);
    drv64(1'b1, 64'h1234, 2'b11, 1'b1, 1'b0, 1'b0);
    tick;
    chk("full InReady32", 64'(b32.InReady), 64'h0);
    chk("full A32", 64'(b32.A), 64'h11);
    drv32(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    drv64(1'b0, 64'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst-asserted InReady64", 64'(b64.InReady), 64'h0);
    tick;
    chk("mrst OutValid32", 64'(b32.OutValid), 64'h0);
    chk("mrst A32", 64'(b32.A), 64'h0);
    chk("mrst RevA32", 64'(b32.RevA), 64'h0);
    chk("mrst B32", 64'(b32.B), 64'h0);
    chk("mrst InReady32", 64'(b32.InReady), 64'h0);
    chk("mrst OutValid64", 64'(b64.OutValid), 64'h0);
    chk("mrst A64", b64.A, 64'h0);
    chk("mrst RevA64", b64.RevA, 64'h0);
    chk("mrst W64_64", 64'(b64.W64), 64'h0);
    reset = 1'b0;
    tick;
    chk("mrst-after InReady32", 64'(b32.InReady), 64'h1);
    chk("mrst-after InReady64", 64'(b64.InReady), 64'h1);
    chk("mrst-after OutValid32", 64'(b32.OutValid), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
